// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared USB receive types and defaults (rx_state_t, SYNC_BYTE_DEF, MAX_ONES_DEF)
package usb_rx_pkg;
  typedef enum logic [1:0] {HUNT, RECV, ERR} rx_state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
  localparam int MAX_ONES_DEF = 6;
endpackage

// File: rtl/rx_byte_assembler_bit_unstuffer.sv
// bit_unstuffer: counts consecutive 1s; load presets 1 at SYNC, en qualifies a data strobe, drop_bit/stuff_violation flag the bit after MAX_ONES 1s
module bit_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int MAX_ONES = MAX_ONES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic d,
  output logic drop_bit,
  output logic stuff_violation
);
  localparam int W = $clog2(MAX_ONES + 1);
  logic [W-1:0] ones_cnt;
  logic full;
  assign full = ones_cnt == W'(MAX_ONES);
  assign drop_bit = en && full && !d;
  assign stuff_violation = en && full && d;
  always_ff @(posedge clk) begin
    if (rst) ones_cnt <= '0;
    else if (load) ones_cnt <= W'(1);
    else if (en) ones_cnt <= (full || !d) ? '0 : ones_cnt + W'(1);
  end
endmodule

// File: rtl/rx_byte_assembler.sv
// rx_byte_assembler: USB RX SYNC hunt, unstuffing and LSB-first byte assembly (in: clk rst shift_en d_orig eop; out: rcv_data byte_received sync_found rx_active stuff_err align_err)
module rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int MAX_ONES = MAX_ONES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       d_orig,
  input  logic       eop,
  output logic [7:0] rcv_data,
  output logic       byte_received,
  output logic       sync_found,
  output logic       rx_active,
  output logic       stuff_err,
  output logic       align_err
);
  rx_state_t state;
  logic [7:0] sr, sr_nx;
  logic [2:0] bit_cnt;
  logic hit, bit_en, drop_bit, stuff_violation;
  assign sr_nx = {d_orig, sr[7:1]};
  assign hit = state == HUNT && shift_en && sr_nx == SYNC_BYTE;
  assign bit_en = state == RECV && shift_en && !eop;
  bit_unstuffer #(.MAX_ONES(MAX_ONES)) u_unstuff (
    .clk(clk),
    .rst(rst),
    .load(hit),
    .en(bit_en),
    .d(d_orig),
    .drop_bit(drop_bit),
    .stuff_violation(stuff_violation)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      sr <= '0;
      rcv_data <= 8'hFF;
      bit_cnt <= '0;
      byte_received <= 1'b0;
      sync_found <= 1'b0;
      rx_active <= 1'b0;
      stuff_err <= 1'b0;
      align_err <= 1'b0;
    end else begin
      byte_received <= 1'b0;
      sync_found <= 1'b0;
      case (state)
        HUNT: if (shift_en) begin
          sr <= sr_nx;
          if (hit) begin
            state <= RECV;
            sync_found <= 1'b1;
            rx_active <= 1'b1;
            bit_cnt <= '0;
            stuff_err <= 1'b0;
            align_err <= 1'b0;
          end
        end
        RECV: if (eop) begin
          state <= HUNT;
          rx_active <= 1'b0;
          if (bit_cnt != '0) align_err <= 1'b1;
        end else if (stuff_violation) begin
          stuff_err <= 1'b1;
          state <= ERR;
        end else if (bit_en && !drop_bit) begin
          sr <= sr_nx;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rcv_data <= sr_nx;
            byte_received <= 1'b1;
          end
        end
        ERR: if (eop) begin
          state <= HUNT;
          rx_active <= 1'b0;
        end
        default: state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_byte_assembler.sv
// tb_rx_byte_assembler: directed and random checks of rx_byte_assembler against a queue-based receive model
module tb_rx_byte_assembler;
  logic clk = 0, rst = 0, shift_en = 0, d_orig = 0, eop = 0;
  logic [7:0] rcv_data;
  logic byte_received, sync_found, rx_active, stuff_err, align_err;
  int n_checks = 0, n_fail = 0, br_cnt = 0;
  int hist[$];
  int dq[$];
  int mode = 0, run = 0;
  logic m_sync = 0, m_br = 0, m_act = 0, m_stuff = 0, m_align = 0;
  logic [7:0] m_data = 8'hFF;
  logic [12:0] obs, expv;
  assign obs = {sync_found, byte_received, rx_active, stuff_err, align_err, rcv_data};
  assign expv = {m_sync, m_br, m_act, m_stuff, m_align, m_data};
  rx_byte_assembler dut (
    .clk(clk),
    .rst(rst),
    .shift_en(shift_en),
    .d_orig(d_orig),
    .eop(eop),
    .rcv_data(rcv_data),
    .byte_received(byte_received),
    .sync_found(sync_found),
    .rx_active(rx_active),
    .stuff_err(stuff_err),
    .align_err(align_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (byte_received) br_cnt++;
  function automatic logic [7:0] pack8(input int q[$]);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = (q[i] != 0);
    return v;
  endfunction
  task automatic m_reset;
    hist = '{0, 0, 0, 0, 0, 0, 0, 0};
    dq.delete();
    mode = 0;
    run = 0;
    m_sync = 0; m_br = 0; m_act = 0; m_stuff = 0; m_align = 0;
    m_data = 8'hFF;
  endtask
  task automatic m_step(input logic se, input logic d, input logic e);
    m_sync = 0;
    m_br = 0;
    if (mode != 0 && e) begin
      if (mode == 1 && dq.size() != 0) m_align = 1;
      mode = 0;
      m_act = 0;
      dq.delete();
    end else if (se && mode == 0) begin
      hist.push_back(int'(d));
      void'(hist.pop_front());
      if (pack8(hist) == 8'h80) begin
        mode = 1; m_sync = 1; m_act = 1; m_stuff = 0; m_align = 0; run = 1;
        dq.delete();
      end
    end else if (se && mode == 1) begin
      if (run == 6) begin
        if (d) begin
          m_stuff = 1;
          mode = 2;
        end else run = 0;
      end else begin
        run = d ? run + 1 : 0;
        dq.push_back(int'(d));
        hist.push_back(int'(d));
        void'(hist.pop_front());
        if (dq.size() == 8) begin
          m_data = pack8(dq);
          m_br = 1;
          dq.delete();
        end
      end
    end
  endtask
  task automatic drive(input logic se, input logic d, input logic e);
    @(negedge clk);
    shift_en = se;
    d_orig = d;
    eop = e;
    m_step(se, d, e);
    @(posedge clk);
    #1;
    shift_en = 0;
    eop = 0;
  endtask
  task automatic do_rst;
    @(negedge clk);
    rst = 1;
    shift_en = 0;
    eop = 0;
    m_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, b[i], 1'b0);
  endtask
  task automatic test_reset;
    do_rst();
    n_checks++;
    if (obs !== 13'h00FF) begin n_fail++; $display("FAIL reset_const obs=%h exp=%h", obs, 13'h00FF); end
    n_checks++;
    if (obs !== expv) begin n_fail++; $display("FAIL reset_model obs=%h exp=%h", obs, expv); end
  endtask
  task automatic test_sync_a5;
    send_bits(8'h80, 8);
    n_checks++;
    if (sync_found !== 1'b1 || rx_active !== 1'b1) begin n_fail++; $display("FAIL sync_pulse sync=%b act=%b exp=1 1", sync_found, rx_active); end
    send_bits(8'hA5, 8);
    n_checks++;
    if (byte_received !== 1'b1 || rcv_data !== 8'hA5) begin n_fail++; $display("FAIL a5_byte br=%b data=%h exp=1 a5", byte_received, rcv_data); end
    n_checks++;
    if (obs !== expv) begin n_fail++; $display("FAIL a5_model obs=%h exp=%h", obs, expv); end
    drive(0, 0, 0);
    n_checks++;
    if (byte_received !== 1'b0 || rcv_data !== 8'hA5) begin n_fail++; $display("FAIL a5_hold br=%b data=%h exp=0 a5", byte_received, rcv_data); end
    drive(0, 0, 1);
    drive(0, 0, 0);
    n_checks++;
    if (rx_active !== 1'b0 || align_err !== 1'b0) begin n_fail++; $display("FAIL a5_eop act=%b align=%b exp=0 0", rx_active, align_err); end
  endtask
  task automatic test_stuff_ff;
    send_bits(8'h80, 8);
    send_bits(8'h1F, 5);
    drive(1, 0, 0);
    n_checks++;
    if (byte_received !== 1'b0 || stuff_err !== 1'b0) begin n_fail++; $display("FAIL stuff_drop br=%b serr=%b exp=0 0", byte_received, stuff_err); end
    send_bits(8'h07, 3);
    n_checks++;
    if (byte_received !== 1'b1 || rcv_data !== 8'hFF || stuff_err !== 1'b0) begin n_fail++; $display("FAIL stuff_ff br=%b data=%h serr=%b exp=1 ff 0", byte_received, rcv_data, stuff_err); end
    n_checks++;
    if (obs !== expv) begin n_fail++; $display("FAIL stuff_ff_model obs=%h exp=%h", obs, expv); end
    drive(0, 0, 1);
  endtask
  task automatic test_stuff_err;
    int c0;
    send_bits(8'h80, 8);
    c0 = br_cnt;
    send_bits(8'h7F, 7);
    n_checks++;
    if (stuff_err !== 1'b1 || rx_active !== 1'b1) begin n_fail++; $display("FAIL stuff_err serr=%b act=%b exp=1 1", stuff_err, rx_active); end
    send_bits(8'h3C, 8);
    drive(0, 0, 0);
    n_checks++;
    if (br_cnt !== c0) begin n_fail++; $display("FAIL err_no_strobe strobes=%0d exp=%0d", br_cnt, c0); end
    drive(0, 0, 1);
    drive(0, 0, 0);
    n_checks++;
    if (rx_active !== 1'b0 || stuff_err !== 1'b1) begin n_fail++; $display("FAIL err_eop act=%b serr=%b exp=0 1", rx_active, stuff_err); end
    send_bits(8'hA5, 8);
    drive(0, 0, 0);
    n_checks++;
    if (br_cnt !== c0 || obs !== expv) begin n_fail++; $display("FAIL err_hunt strobes=%0d obs=%h exp=%0d %h", br_cnt, obs, c0, expv); end
  endtask
  task automatic test_align;
    int c0;
    send_bits(8'h80, 8);
    c0 = br_cnt;
    send_bits(8'h2D, 8);
    send_bits(8'h05, 3);
    drive(0, 0, 1);
    drive(0, 0, 0);
    n_checks++;
    if (br_cnt - c0 !== 1 || align_err !== 1'b1 || rcv_data !== 8'h2D) begin n_fail++; $display("FAIL align strobes=%0d align=%b data=%h exp=1 1 2d", br_cnt - c0, align_err, rcv_data); end
    send_bits(8'h80, 8);
    n_checks++;
    if (align_err !== 1'b0 || sync_found !== 1'b1) begin n_fail++; $display("FAIL align_clear align=%b sync=%b exp=0 1", align_err, sync_found); end
    drive(0, 0, 1);
  endtask
  task automatic test_eop_8th;
    int c0;
    send_bits(8'h80, 8);
    c0 = br_cnt;
    send_bits(8'h2D, 7);
    drive(1, 0, 1);
    n_checks++;
    if (byte_received !== 1'b0 || align_err !== 1'b1 || rx_active !== 1'b0) begin n_fail++; $display("FAIL eop_8th br=%b align=%b act=%b exp=0 1 0", byte_received, align_err, rx_active); end
    send_bits(8'hA5, 8);
    drive(0, 0, 0);
    n_checks++;
    if (br_cnt !== c0) begin n_fail++; $display("FAIL eop_8th_hunt strobes=%0d exp=%0d", br_cnt, c0); end
  endtask
  task automatic test_rst_mid;
    send_bits(8'h80, 8);
    send_bits(8'h0B, 4);
    do_rst();
    n_checks++;
    if (obs !== 13'h00FF) begin n_fail++; $display("FAIL rst_mid obs=%h exp=%h", obs, 13'h00FF); end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL rst_garbage cyc=%0d obs=%h exp=%h", i, obs, expv); end
    end
    drive(0, 0, 1);
  endtask
  task automatic test_back_to_back;
    send_bits(8'h80, 8);
    send_bits(8'h3C, 8);
    n_checks++;
    if (byte_received !== 1'b1 || rcv_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_first br=%b data=%h exp=1 3c", byte_received, rcv_data); end
    send_bits(8'hC3, 8);
    n_checks++;
    if (byte_received !== 1'b1 || rcv_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_second br=%b data=%h exp=1 c3", byte_received, rcv_data); end
    drive(0, 0, 1);
  endtask
  task automatic test_random;
    logic [2:0] stim[$];
    logic [7:0] sb;
    logic biased;
    int n;
    sb = 8'h80;
    for (int p = 0; p < 40; p++) begin
      stim.delete();
      biased = p[0];
      n = 8 * $urandom_range(0, 3) + $urandom_range(0, 9);
      for (int i = 0; i < $urandom_range(0, 3); i++) stim.push_back(3'b000);
      for (int i = 0; i < 8; i++) stim.push_back({1'b1, sb[i], 1'b0});
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) stim.push_back(3'b000);
        stim.push_back({1'b1, biased ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1)), 1'b0});
      end
      stim.push_back({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
      if ($urandom_range(0, 1) == 1) stim.push_back(3'b001);
      stim.push_back(3'b000);
      foreach (stim[i]) begin
        drive(stim[i][2], stim[i][1], stim[i][0]);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL random pkt=%0d cyc=%0d obs=%h exp=%h", p, i, obs, expv); end
      end
    end
  endtask
  initial begin
    m_reset();
    test_reset();
    test_sync_a5();
    test_stuff_ff();
    test_stuff_err();
    test_align();
    test_eop_8th();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
